// File: rtl/heap_sched_if.sv
// Command/status bundle between the EX/MEM stage and the heap scheduler.
// The pipeline side drives commands and the EX/MEM stall; the scheduler returns stall, top and status.
interface heap_sched_if #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 32
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [1:0]      heap_i;
   logic [XLEN-1:0] ctx_memaddr_i;
   logic [XLEN-1:0] task_priority_i;
   logic            ex_stall_i;
   logic            heap_stall_o;
   logic            top_valid_o;
   logic [XLEN-1:0] top_ctx_memaddr_o;
   logic [XLEN-1:0] top_priority_o;
   logic [CW-1:0]   count_o;
   logic            full_o;
   logic            err_o;

   modport slave (
      input  heap_i, ctx_memaddr_i, task_priority_i, ex_stall_i,
      output heap_stall_o, top_valid_o, top_ctx_memaddr_o, top_priority_o, count_o, full_o, err_o
   );

   modport master (
      output heap_i, ctx_memaddr_i, task_priority_i, ex_stall_i,
      input  heap_stall_o, top_valid_o, top_ctx_memaddr_o, top_priority_o, count_o, full_o, err_o
   );
endinterface

// File: rtl/heap_sched.sv
// Register-based binary max-heap of {priority, ctx_memaddr} for the task scheduler.
// Each operation runs one compare/swap per cycle while the pipeline is held by heap_stall_o.
module heap_sched #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   heap_sched_if.slave  bus
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [1:0] CMD_NONE    = 2'b00;
   localparam logic [1:0] CMD_INSERT  = 2'b01;
   localparam logic [1:0] CMD_DEL_TOP = 2'b10;
   localparam logic [1:0] CMD_DEL_TSK = 2'b11;

   typedef enum logic [1:0] {StIdle, StSiftUp, StSiftDown, StSearch} state_e;

   state_e          r_state, w_state_d;
   logic [XLEN-1:0] r_pri    [DEPTH];
   logic [XLEN-1:0] r_addr   [DEPTH];
   logic [XLEN-1:0] w_pri_d  [DEPTH];
   logic [XLEN-1:0] w_addr_d [DEPTH];
   logic [CW-1:0]   r_count, w_count_d;
   logic [IW-1:0]   r_idx, w_idx_d;
   logic            r_hold;
   logic            r_chain, w_chain_d;
   logic            w_done, w_err, w_stall;

   logic [IW-1:0]   w_last;
   logic [IW-1:0]   w_parent;
   logic [CW:0]     w_lchild, w_rchild;
   logic [IW-1:0]   w_lc, w_rc, w_child;
   logic            w_lvalid, w_rvalid;

   assign w_last   = IW'(r_count - CW'(1));
   assign w_parent = (r_idx - 1'b1) >> 1;
   assign w_lchild = {1'b0, r_idx, 1'b1};
   assign w_rchild = w_lchild + 1'b1;
   assign w_lvalid = w_lchild < {1'b0, r_count};
   assign w_rvalid = w_rchild < {1'b0, r_count};
   assign w_lc     = w_lchild[IW-1:0];
   assign w_rc     = w_rchild[IW-1:0];
   // Ties between children go left.
   assign w_child  = (w_rvalid && (r_pri[w_rc] > r_pri[w_lc])) ? w_rc : w_lc;

   always_comb begin
      w_state_d = r_state;
      w_pri_d   = r_pri;
      w_addr_d  = r_addr;
      w_count_d = r_count;
      w_idx_d   = r_idx;
      w_chain_d = r_chain;
      w_done    = 1'b0;
      w_err     = 1'b0;
      w_stall   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.heap_i != CMD_NONE && !r_hold) begin
               case (bus.heap_i)
                  CMD_INSERT: begin
                     if (r_count == FULL_CNT) begin
                        w_err  = 1'b1;
                        w_done = 1'b1;
                     end else begin
                        w_pri_d[r_count[IW-1:0]]  = bus.task_priority_i;
                        w_addr_d[r_count[IW-1:0]] = bus.ctx_memaddr_i;
                        w_count_d = r_count + 1'b1;
                        w_idx_d   = r_count[IW-1:0];
                        w_chain_d = 1'b0;
                        w_state_d = StSiftUp;
                        w_stall   = 1'b1;
                     end
                  end
                  CMD_DEL_TOP: begin
                     if (r_count == '0) begin
                        w_err  = 1'b1;
                        w_done = 1'b1;
                     end else begin
                        w_pri_d[0]  = r_pri[w_last];
                        w_addr_d[0] = r_addr[w_last];
                        w_count_d   = r_count - 1'b1;
                        w_idx_d     = '0;
                        w_state_d   = StSiftDown;
                        w_stall     = 1'b1;
                     end
                  end
                  CMD_DEL_TSK: begin
                     if (r_count == '0) begin
                        w_err  = 1'b1;
                        w_done = 1'b1;
                     end else begin
                        w_idx_d   = '0;
                        w_state_d = StSearch;
                        w_stall   = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         StSearch: begin
            // The match key is still on ctx_memaddr_i because EX/MEM is stalled.
            if (r_addr[r_idx] == bus.ctx_memaddr_i) begin
               w_pri_d[r_idx]  = r_pri[w_last];
               w_addr_d[r_idx] = r_addr[w_last];
               w_count_d = r_count - 1'b1;
               w_chain_d = 1'b1;
               w_state_d = StSiftUp;
               w_stall   = 1'b1;
            end else if (r_idx == w_last) begin
               w_err     = 1'b1;
               w_done    = 1'b1;
               w_state_d = StIdle;
            end else begin
               w_idx_d = r_idx + 1'b1;
               w_stall = 1'b1;
            end
         end
         StSiftUp: begin
            if (r_idx == '0 || r_pri[w_parent] >= r_pri[r_idx]) begin
               // A replaced entry that did not move up may still need to move down.
               if (r_chain) begin
                  w_chain_d = 1'b0;
                  w_state_d = StSiftDown;
                  w_stall   = 1'b1;
               end else begin
                  w_done    = 1'b1;
                  w_state_d = StIdle;
               end
            end else begin
               w_pri_d[r_idx]     = r_pri[w_parent];
               w_addr_d[r_idx]    = r_addr[w_parent];
               w_pri_d[w_parent]  = r_pri[r_idx];
               w_addr_d[w_parent] = r_addr[r_idx];
               w_idx_d   = w_parent;
               w_chain_d = 1'b0;
               w_stall   = 1'b1;
            end
         end
         StSiftDown: begin
            if (!w_lvalid || r_pri[w_child] <= r_pri[r_idx]) begin
               w_done    = 1'b1;
               w_state_d = StIdle;
            end else begin
               w_pri_d[r_idx]    = r_pri[w_child];
               w_addr_d[r_idx]   = r_addr[w_child];
               w_pri_d[w_child]  = r_pri[r_idx];
               w_addr_d[w_child] = r_addr[r_idx];
               w_idx_d = w_child;
               w_stall = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_pri   <= '{default: '0};
         r_addr  <= '{default: '0};
         r_count <= '0;
         r_idx   <= '0;
         r_hold  <= 1'b0;
         r_chain <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_pri   <= w_pri_d;
         r_addr  <= w_addr_d;
         r_count <= w_count_d;
         r_idx   <= w_idx_d;
         r_chain <= w_chain_d;
         // Blocks re-execution of a completed command still held in EX/MEM.
         r_hold  <= bus.ex_stall_i & (r_hold | w_done);
      end
   end

   assign bus.heap_stall_o      = w_stall & ~rst_i;
   assign bus.err_o             = w_err & ~rst_i;
   assign bus.count_o           = r_count;
   assign bus.full_o            = (r_count == FULL_CNT);
   assign bus.top_valid_o       = (r_count != '0);
   assign bus.top_priority_o    = (r_count != '0) ? r_pri[0] : '0;
   assign bus.top_ctx_memaddr_o = (r_count != '0) ? r_addr[0] : '0;
endmodule

// File: tb/tb_heap_sched.sv
// Self-checking bench for heap_sched: directed scenarios plus randomized commands
// compared against an array-based priority-queue model.
module tb_heap_sched;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;
   localparam logic [1:0] C_INS = 2'b01;
   localparam logic [1:0] C_TOP = 2'b10;
   localparam logic [1:0] C_TSK = 2'b11;

   logic clk = 1'b0;
   logic rst;
   logic ext_stall;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_stall, last_err;

   logic [31:0] m_pri  [DEPTH];
   logic [31:0] m_addr [DEPTH];
   int          m_cnt;

   heap_sched_if #(.DEPTH(DEPTH), .XLEN(XLEN)) hif ();

   heap_sched #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (hif.slave)
   );

   assign hif.ex_stall_i = hif.heap_stall_o | ext_stall;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic m_swap(input int i, input int j);
      logic [31:0] tp, ta;
      tp = m_pri[i];  ta = m_addr[i];
      m_pri[i] = m_pri[j];  m_addr[i] = m_addr[j];
      m_pri[j] = tp;        m_addr[j] = ta;
   endtask

   task automatic m_up(input int start, output int k);
      int i = start;
      k = 0;
      while (i > 0 && m_pri[(i - 1) / 2] < m_pri[i]) begin
         m_swap(i, (i - 1) / 2);
         i = (i - 1) / 2;
         k++;
      end
   endtask

   task automatic m_down(input int start, output int k);
      int i = start;
      int c;
      k = 0;
      while (2 * i + 1 < m_cnt) begin
         c = 2 * i + 1;
         if (c + 1 < m_cnt && m_pri[c + 1] > m_pri[c]) c = c + 1;
         if (m_pri[c] <= m_pri[i]) break;
         m_swap(i, c);
         i = c;
         k++;
      end
   endtask

   task automatic model_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] p,
                           output int st, output int er);
      int k, k2, j;
      st = 0;
      er = 0;
      case (cmd)
         C_INS: begin
            if (m_cnt == DEPTH) er = 1;
            else begin
               m_pri[m_cnt] = p;
               m_addr[m_cnt] = a;
               m_cnt++;
               m_up(m_cnt - 1, k);
               st = 1 + k;
            end
         end
         C_TOP: begin
            if (m_cnt == 0) er = 1;
            else begin
               m_pri[0] = m_pri[m_cnt - 1];
               m_addr[0] = m_addr[m_cnt - 1];
               m_cnt--;
               m_down(0, k);
               st = 1 + k;
            end
         end
         C_TSK: begin
            if (m_cnt == 0) er = 1;
            else begin
               j = -1;
               for (int i = m_cnt - 1; i >= 0; i--) if (m_addr[i] == a) j = i;
               if (j < 0) begin
                  er = 1;
                  st = m_cnt;
               end else begin
                  m_pri[j] = m_pri[m_cnt - 1];
                  m_addr[j] = m_addr[m_cnt - 1];
                  m_cnt--;
                  m_up(j, k);
                  st = 1 + (j + 1) + k;
                  if (k == 0) begin
                     m_down(j, k2);
                     st += 1 + k2;
                  end
               end
            end
         end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] m_max();
      logic [31:0] mx = 0;
      for (int i = 0; i < m_cnt; i++) if (m_pri[i] > mx) mx = m_pri[i];
      return mx;
   endfunction

   // ---------------- drivers ----------------
   task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] p,
                         input bit keep, output int st, output int er);
      bit done = 0;
      st = 0;
      er = 0;
      hif.heap_i = cmd;
      hif.ctx_memaddr_i = a;
      hif.task_priority_i = p;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (hif.err_o) er++;
         if (hif.heap_stall_o) st++;
         else begin
            done = 1;
            break;
         end
      end
      if (!done) check("op_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!keep) hif.heap_i = 2'b00;
   endtask

   task automatic check_state();
      @(negedge clk);
      check("count", 32'(hif.count_o), m_cnt);
      check("full", 32'(hif.full_o), 32'(m_cnt == DEPTH));
      check("top_valid", 32'(hif.top_valid_o), 32'(m_cnt != 0));
      check("top_pri", hif.top_priority_o, m_max());
      check("top_addr", hif.top_ctx_memaddr_o, (m_cnt != 0) ? m_addr[0] : 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] p);
      int es, ee;
      model_op(cmd, a, p, es, ee);
      run_op(cmd, a, p, 1'b0, last_stall, last_err);
      check("stall_cycles", last_stall, es);
      check("err_pulses", last_err, ee);
      check_state();
   endtask

   initial begin
      int gs, ge, es, ee, prev;
      logic [31:0] drain [7];
      logic [1:0] cmd;
      drain = '{32'd8, 32'd7, 32'd6, 32'd4, 32'd3, 32'd2, 32'd1};
      m_pri = '{default: '0};
      m_addr = '{default: '0};
      m_cnt = 0;
      rst = 1'b1;
      ext_stall = 1'b0;
      hif.heap_i = 2'b00;
      hif.ctx_memaddr_i = '0;
      hif.task_priority_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_count", 32'(hif.count_o), 0);
      check("rst_valid", 32'(hif.top_valid_o), 0);
      check("rst_pri", hif.top_priority_o, 0);
      check("rst_addr", hif.top_ctx_memaddr_o, 0);
      check("rst_full", 32'(hif.full_o), 0);
      check("rst_stall", 32'(hif.heap_stall_o), 0);
      check("rst_err", 32'(hif.err_o), 0);
      @(posedge clk);
      #1;

      // Insert ordering
      do_cmd(C_INS, 32'h100, 32'd5);
      do_cmd(C_INS, 32'h200, 32'd9);
      check("ins2_stall", last_stall, 2);
      check("ins2_top_pri", hif.top_priority_o, 9);
      check("ins2_top_addr", hif.top_ctx_memaddr_o, 32'h200);
      do_cmd(C_INS, 32'h300, 32'd3);
      do_cmd(C_INS, 32'h400, 32'd9);
      check("ins4_top_addr", hif.top_ctx_memaddr_o, 32'h200);
      check("ins4_count", 32'(hif.count_o), 4);

      // Delete top x3
      do_cmd(C_TOP, 0, 0);
      check("dt1", {hif.top_priority_o[15:0], hif.top_ctx_memaddr_o[15:0]}, 32'h0009_0400);
      check("dt1_cnt", 32'(hif.count_o), 3);
      do_cmd(C_TOP, 0, 0);
      check("dt2", {hif.top_priority_o[15:0], hif.top_ctx_memaddr_o[15:0]}, 32'h0005_0100);
      check("dt2_cnt", 32'(hif.count_o), 2);
      do_cmd(C_TOP, 0, 0);
      check("dt3", {hif.top_priority_o[15:0], hif.top_ctx_memaddr_o[15:0]}, 32'h0003_0300);
      check("dt3_cnt", 32'(hif.count_o), 1);
      do_cmd(C_TOP, 0, 0);

      // Empty delete-top
      do_cmd(C_TOP, 0, 0);
      check("empty_err", last_err, 1);
      check("empty_stall", last_stall, 0);
      check("empty_valid", 32'(hif.top_valid_o), 0);

      // Fill 1..8, overflow, delete-task
      for (int i = 1; i <= 8; i++) do_cmd(C_INS, 32'(i * 16), 32'(i));
      check("full_flag", 32'(hif.full_o), 1);
      do_cmd(C_INS, 32'h900, 32'd99);
      check("ovf_err", last_err, 1);
      check("ovf_count", 32'(hif.count_o), 8);
      do_cmd(C_TSK, 32'h50, 0);
      check("dtask_count", 32'(hif.count_o), 7);
      check("dtask_err", last_err, 0);
      do_cmd(C_TSK, 32'h999, 0);
      check("dtask_miss_err", last_err, 1);
      check("dtask_miss_count", 32'(hif.count_o), 7);
      for (int i = 0; i < 7; i++) begin
         check("drain_pri", hif.top_priority_o, drain[i]);
         check("drain_addr", hif.top_ctx_memaddr_o, drain[i] * 16);
         do_cmd(C_TOP, 0, 0);
      end

      // Hold guard: command stays on heap_i while EX/MEM is stalled after completion
      prev = m_cnt;
      ext_stall = 1'b1;
      model_op(C_INS, 32'hA0, 32'd7, es, ee);
      run_op(C_INS, 32'hA0, 32'd7, 1'b1, gs, ge);
      check("hold_stall", gs, es);
      gs = 0;
      repeat (5) begin
         @(negedge clk);
         if (hif.heap_stall_o || hif.err_o) gs++;
         @(posedge clk);
         #1;
      end
      ext_stall = 1'b0;
      @(negedge clk);
      if (hif.heap_stall_o || hif.err_o) gs++;
      @(posedge clk);
      #1 hif.heap_i = 2'b00;
      check("hold_reexec", gs, 0);
      check("hold_count", 32'(hif.count_o), prev + 1);
      do_cmd(C_TOP, 0, 0);

      // Reset during SIFTDOWN
      for (int i = 1; i <= 4; i++) do_cmd(C_INS, 32'(i * 16), 32'(i));
      hif.heap_i = C_TOP;
      @(negedge clk);
      check("midrst_accept", 32'(hif.heap_stall_o), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_stall", 32'(hif.heap_stall_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hif.heap_i = 2'b00;
      m_cnt = 0;
      m_pri = '{default: '0};
      m_addr = '{default: '0};
      check_state();
      check("midrst_valid", 32'(hif.top_valid_o), 0);

      // Randomized commands
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0, 1: cmd = C_INS;
            2: cmd = C_TOP;
            default: cmd = C_TSK;
         endcase
         do_cmd(cmd, 32'($urandom_range(1, 6) * 16), 32'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/heap_sched.md
# heap_sched

Hardware priority-queue controller for the task-scheduling extension. It receives heap commands (insert, delete-top, delete-task) from the EX/MEM stage register and maintains a binary max-heap of `{priority, ctx_memaddr}` entries in registers. Each heap operation is sequenced as one compare/swap per cycle, and the pipeline is stalled until the operation finishes. The current top entry is presented continuously to the context-switch logic.

## Interface
- `DEPTH`, default 8: number of heap entries; must be a power of two, ≥2.
- `XLEN`, default 32: width of the priority and address fields.

- `clk_i` input 1: clock.
- `rst_i` input 1: reset. One clock; reset is synchronous and active-high.
- `heap_i` input 2: command from EX/MEM.
  - 00 = none, 01 = insert, 10 = delete top, 11 = delete task.
- `ctx_memaddr_i` input XLEN: task context address (insert key, delete-task match key).
- `task_priority_i` input XLEN: unsigned priority (insert only); larger value = higher priority.
- `ex_stall_i` input 1: stall currently applied to the EX/MEM register; 0 means `heap_i` will hold a new command next cycle.
- `heap_stall_o` output 1: combinational pipeline stall request to pipectrl.
- `top_valid_o` output 1: heap non-empty.
- `top_ctx_memaddr_o` output XLEN: `ctx_memaddr` of entry[0], or 0 when empty.
- `top_priority_o` output XLEN: priority of entry[0], or 0 when empty.
- `count_o` output log2(DEPTH)+1: number of valid entries.
- `full_o` output 1: `count_o == DEPTH`.
- `err_o` output 1: one-cycle pulse when a command is rejected.

## Operation
- **Storage:** arrays `pri[DEPTH]`, `addr[DEPTH]`, plus `count`, `idx`, `state`. Entry i has parent (i-1)>>1 and children 2i+1 and 2i+2; only entries < count are valid.
- **Accept:**
  - A command is accepted when state=IDLE, `heap_i`≠0 and `hold`=0.
  - `hold` is set on the cycle a command completes and cleared on any cycle with `ex_stall_i`=0. This prevents a still-held command from being re-executed.
- **States:** IDLE, SIFTUP, SIFTDOWN, SEARCH.
- **Insert:**
  - If full: `err_o`=1 and no change.
  - Otherwise write entry[count], increment count, set idx=old count, go to SIFTUP.
- **Delete top:**
  - If empty: `err_o`=1.
  - Otherwise entry[0]←entry[count-1], decrement count, idx=0, go to SIFTDOWN.
- **Delete task:**
  - If empty: `err_o`=1.
  - Otherwise idx=0, go to SEARCH.
  - SEARCH: if `addr[idx]`==`ctx_memaddr_i` (input held by the stall), set entry[idx]←entry[count-1], decrement count, go to SIFTUP at idx. Otherwise increment idx.
  - If idx reaches count-1 without a match: `err_o`=1, no change, go to IDLE.
  - On a match while in SIFTUP, a termination without any swap continues into SIFTDOWN at the same idx.
- **SIFTUP:**
  - If idx=0 or `pri[parent]` ≥ `pri[idx]`: done.
  - Otherwise swap with the parent, idx=parent.
- **SIFTDOWN:**
  - Pick the larger valid child; ties go to the left child.
  - If there is no valid child or `pri[child]` ≤ `pri[idx]`: done. Otherwise swap, idx=child.
- Strict comparisons are used, so equal priorities never swap and earlier-inserted entries stay above later ones along a path.
- Done returns the FSM to IDLE. Rejected commands complete in their accept cycle.
- Duplicate `ctx_memaddr` entries are allowed; delete-task removes the lowest-index match.

## Timing
- **Reset values:** all outputs 0; `count`, `idx`, `hold` = 0; state=IDLE; array contents 0.
- **`heap_stall_o`:**
  - Asserted from the accept cycle through every busy cycle.
  - Deasserted in the completing cycle, so EX/MEM advances on that edge.
  - In IDLE with no accepted command it is 0.
- **Latency** (k = number of swaps, m = search cycles):
  - Insert: stall high 1+k cycles.
  - Delete top: stall high 1+k cycles.
  - Delete task: stall high 1+m+k(+1 if it transitions SIFTUP→SIFTDOWN).
  - Reject: stall 0, `err_o` pulses in the accept cycle.
- `top_*`, `count_o` and `full_o` are registered from the arrays and update the cycle after each write. They may show intermediate heap states while busy; consumers sample them only when `heap_stall_o`=0.
- **Reset mid-operation:** the heap is emptied, the FSM returns to IDLE and stall drops in the reset cycle.
- A flush zeroes `heap_i` upstream. An already accepted operation still runs to completion.

## Test plan
- **Insert ordering:** insert pri 5, 9, 3, 9 (addr 0x100, 0x200, 0x300, 0x400).
  - Top = 9/0x200 after the second insert.
  - Second 9 does not displace 0x200.
  - count_o=4; the 2nd insert stalls 2 cycles.
- **Delete top:** from that heap, delete top three times.
  - Tops seen: 9/0x400, then 5/0x100, then 3/0x300.
  - count_o = 3, 2, 1.
- **Delete task:** insert 1..8 (pri=i, addr=i·0x10), delete task 0x50.
  - count_o=7; the heap property holds over all 7 entries.
  - Delete task 0x999: `err_o` pulses, count unchanged.
- **Full/empty:**
  - A 9th insert at DEPTH=8 sets `err_o` with `full_o`=1 and no change.
  - Delete top on empty sets `err_o`, `top_valid_o`=0, stall 0.
- **Hold guard:** insert with `ex_stall_i` held 1 for 4 cycles after completion → executes exactly once (count +1).
- **Reset mid-op:** assert `rst_i` during SIFTDOWN → next cycle count_o=0, `heap_stall_o`=0, `top_valid_o`=0.
